// File: rtl/mic4_pulse_sequencer_if.sv
// Control/status bundle between the pulse sequencer and its configuring master.
// The master drives the start/abort/config side; the sequencer drives the MIC4-facing outputs.
interface mic4_pulse_sequencer_if #(
    parameter int DIV_WIDTH = 6,
    parameter int GAP_WIDTH = 16,
    parameter int REP_WIDTH = 16
);
    logic                 start;
    logic                 abort;
    logic [DIV_WIDTH-1:0] cfg_div0;
    logic [DIV_WIDTH-1:0] cfg_div1;
    logic [GAP_WIDTH-1:0] cfg_gap_ga;
    logic [GAP_WIDTH-1:0] cfg_gap_ad;
    logic [GAP_WIDTH-1:0] cfg_gap_next;
    logic [REP_WIDTH-1:0] cfg_repeat;
    logic [2:0]           cfg_en;

    logic [DIV_WIDTH-1:0] div0;
    logic [DIV_WIDTH-1:0] div1;
    logic                 pulse_grst;
    logic                 pulse_a;
    logic                 pulse_d;
    logic                 busy;
    logic                 done;
    logic [REP_WIDTH-1:0] iter_cnt;

    modport master (
        output start, abort, cfg_div0, cfg_div1, cfg_gap_ga, cfg_gap_ad,
               cfg_gap_next, cfg_repeat, cfg_en,
        input  div0, div1, pulse_grst, pulse_a, pulse_d, busy, done, iter_cnt
    );

    modport slave (
        input  start, abort, cfg_div0, cfg_div1, cfg_gap_ga, cfg_gap_ad,
               cfg_gap_next, cfg_repeat, cfg_en,
        output div0, div1, pulse_grst, pulse_a, pulse_d, busy, done, iter_cnt
    );
endinterface

// File: rtl/mic4_pulse_sequencer.sv
// Cycle-exact GRST -> A -> D pulse scheduler for the MIC4 control block, with divider
// load and settle wait up front. All outputs come straight from flops.
module mic4_pulse_sequencer #(
    parameter int DIV_WIDTH     = 6,
    parameter int GAP_WIDTH     = 16,
    parameter int REP_WIDTH     = 16,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                   clk_control,
    input  logic                   rst,
    mic4_pulse_sequencer_if.slave  bus
);

    localparam int SETTLE_WIDTH = $clog2(SETTLE_CYCLES + 1);
    localparam int CNT_WIDTH    = (GAP_WIDTH > SETTLE_WIDTH) ? GAP_WIDTH : SETTLE_WIDTH;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETTLE,
        S_GRST,
        S_WAIT_GA,
        S_APULSE,
        S_WAIT_AD,
        S_DPULSE,
        S_WAIT_NEXT,
        S_DONE
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;

    // Shadow copies of the run configuration, frozen at start.
    logic [GAP_WIDTH-1:0] gap_ga;
    logic [GAP_WIDTH-1:0] gap_ad;
    logic [GAP_WIDTH-1:0] gap_next;
    logic [REP_WIDTH-1:0] rep_eff;
    logic [2:0]           en;

    logic [DIV_WIDTH-1:0] div0_q;
    logic [DIV_WIDTH-1:0] div1_q;
    logic                 pulse_grst_q;
    logic                 pulse_a_q;
    logic                 pulse_d_q;
    logic                 busy_q;
    logic                 done_q;
    logic [REP_WIDTH-1:0] iter_q;

    logic [REP_WIDTH-1:0] iter_inc;
    logic                 last_iter;

    always_comb begin
        iter_inc  = (iter_q == '1) ? iter_q : iter_q + 1'b1;
        last_iter = (iter_inc >= rep_eff);
    end

    always_ff @(posedge clk_control) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            gap_ga       <= '0;
            gap_ad       <= '0;
            gap_next     <= '0;
            rep_eff      <= '0;
            en           <= '0;
            div0_q       <= '0;
            div1_q       <= '0;
            pulse_grst_q <= 1'b0;
            pulse_a_q    <= 1'b0;
            pulse_d_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            iter_q       <= '0;
        end else begin
            // NOTE: strobes default low each cycle and are raised on the edge entering their
            // state, so they stay registered and exactly one cycle wide.
            pulse_grst_q <= 1'b0;
            pulse_a_q    <= 1'b0;
            pulse_d_q    <= 1'b0;
            done_q       <= 1'b0;

            if (state != S_IDLE && bus.abort) begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            gap_ga   <= bus.cfg_gap_ga;
                            gap_ad   <= bus.cfg_gap_ad;
                            gap_next <= bus.cfg_gap_next;
                            rep_eff  <= (bus.cfg_repeat == '0) ? REP_WIDTH'(1) : bus.cfg_repeat;
                            en       <= bus.cfg_en;
                            div0_q   <= bus.cfg_div0;
                            div1_q   <= bus.cfg_div1;
                            iter_q   <= '0;
                            cnt      <= CNT_WIDTH'(SETTLE_CYCLES - 1);
                            busy_q   <= 1'b1;
                            state    <= S_SETTLE;
                        end
                    end

                    S_SETTLE, S_WAIT_NEXT: begin
                        if (cnt == '0) begin
                            state        <= S_GRST;
                            pulse_grst_q <= en[0];
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end

                    S_GRST: begin
                        if (gap_ga == '0) begin
                            state     <= S_APULSE;
                            pulse_a_q <= en[1];
                        end else begin
                            state <= S_WAIT_GA;
                            cnt   <= CNT_WIDTH'(gap_ga - 1'b1);
                        end
                    end

                    S_WAIT_GA: begin
                        if (cnt == '0) begin
                            state     <= S_APULSE;
                            pulse_a_q <= en[1];
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end

                    S_APULSE: begin
                        if (gap_ad == '0) begin
                            state     <= S_DPULSE;
                            pulse_d_q <= en[2];
                        end else begin
                            state <= S_WAIT_AD;
                            cnt   <= CNT_WIDTH'(gap_ad - 1'b1);
                        end
                    end

                    S_WAIT_AD: begin
                        if (cnt == '0) begin
                            state     <= S_DPULSE;
                            pulse_d_q <= en[2];
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end

                    S_DPULSE: begin
                        iter_q <= iter_inc;
                        if (last_iter) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else if (gap_next == '0) begin
                            state        <= S_GRST;
                            pulse_grst_q <= en[0];
                        end else begin
                            state <= S_WAIT_NEXT;
                            cnt   <= CNT_WIDTH'(gap_next - 1'b1);
                        end
                    end

                    S_DONE: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end

                    default: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.div0       = div0_q;
    assign bus.div1       = div1_q;
    assign bus.pulse_grst = pulse_grst_q;
    assign bus.pulse_a    = pulse_a_q;
    assign bus.pulse_d    = pulse_d_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.iter_cnt   = iter_q;

endmodule

// File: tb/tb_mic4_pulse_sequencer.sv
// Directed bench for mic4_pulse_sequencer: pulse/done cycle numbers are logged relative to
// the start edge E0 (cycle k lies between edges E0+k-1 and E0+k) and compared with hand values.
module tb_mic4_pulse_sequencer;

    localparam int DW = 6;
    localparam int GW = 16;
    localparam int RW = 16;
    localparam int SC = 4;

    logic clk_control = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;
    int edge_no = 0;
    int e0 = 0;
    int mon_k;
    bit mon_en = 1'b0;
    int q_grst[$];
    int q_a[$];
    int q_d[$];
    int q_done[$];

    mic4_pulse_sequencer_if #(.DIV_WIDTH(DW), .GAP_WIDTH(GW), .REP_WIDTH(RW)) bus ();

    mic4_pulse_sequencer #(
        .DIV_WIDTH(DW), .GAP_WIDTH(GW), .REP_WIDTH(RW), .SETTLE_CYCLES(SC)
    ) dut (
        .clk_control(clk_control),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk_control = ~clk_control;

    always @(posedge clk_control) edge_no++;

    always @(negedge clk_control) begin
        if (mon_en) begin
            mon_k = edge_no - e0 + 1;
            if (bus.pulse_grst) q_grst.push_back(mon_k);
            if (bus.pulse_a)    q_a.push_back(mon_k);
            if (bus.pulse_d)    q_d.push_back(mon_k);
            if (bus.done)       q_done.push_back(mon_k);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    function automatic string qstr(input int q[$]);
        string s;
        s = "";
        foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
        if (q.size() == 0) s = "none";
        return s;
    endfunction

    task automatic clear_log();
        q_grst.delete();
        q_a.delete();
        q_d.delete();
        q_done.delete();
    endtask

    task automatic set_cfg(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input logic [GW-1:0] ga, input logic [GW-1:0] ad,
                           input logic [GW-1:0] nx, input logic [RW-1:0] rep,
                           input logic [2:0] en);
        bus.cfg_div0     = d0;
        bus.cfg_div1     = d1;
        bus.cfg_gap_ga   = ga;
        bus.cfg_gap_ad   = ad;
        bus.cfg_gap_next = nx;
        bus.cfg_repeat   = rep;
        bus.cfg_en       = en;
    endtask

    // Called at a negedge; returns at the negedge of cycle 1.
    task automatic do_start();
        clear_log();
        e0        = edge_no + 1;
        mon_en    = 1'b1;
        bus.start = 1'b1;
        @(negedge clk_control);
        bus.start = 1'b0;
    endtask

    task automatic wait_cycle(input int k);
        while (edge_no - e0 + 1 < k) @(negedge clk_control);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (bus.busy && n < budget) begin
            @(negedge clk_control);
            n++;
        end
        checks++;
        if (bus.busy) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", name, bus.busy, budget);
        end
    endtask

    task automatic test_reset();
        bit seen;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_cfg('0, '0, '0, '0, '0, '0, '0);
        rst = 1'b1;
        repeat (5) @(negedge clk_control);
        rst = 1'b0;
        @(negedge clk_control);
        checks++;
        if ({bus.div0, bus.div1, bus.pulse_grst, bus.pulse_a, bus.pulse_d,
             bus.busy, bus.done, bus.iter_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: div0=%0d div1=%0d p=%b%b%b busy=%b done=%b iter=%0d, expected all 0",
                     bus.div0, bus.div1, bus.pulse_grst, bus.pulse_a, bus.pulse_d,
                     bus.busy, bus.done, bus.iter_cnt);
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk_control);
            if (bus.busy !== 1'b0 || bus.pulse_grst !== 1'b0 || bus.done !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_idle: activity seen during 20 idle cycles, expected none");
        end
    endtask

    task automatic test_basic();
        set_cfg(6'd2, 6'd4, 16'd3, 16'd5, 16'd10, 16'd2, 3'b111);
        do_start();
        checks++;
        if (bus.busy !== 1'b1 || bus.div0 !== 6'd2 || bus.div1 !== 6'd4) begin
            errors++;
            $display("FAIL basic_start: busy=%b div0=%0d div1=%0d, expected 1 2 4", bus.busy, bus.div0, bus.div1);
        end
        wait_idle("basic", 100);
        checks++;
        if (q_grst.size() != 2 || q_grst[0] != 5 || q_grst[1] != 26) begin
            errors++;
            $display("FAIL basic_grst: got %s expected 5 26", qstr(q_grst));
        end
        checks++;
        if (q_a.size() != 2 || q_a[0] != 9 || q_a[1] != 30) begin
            errors++;
            $display("FAIL basic_a: got %s expected 9 30", qstr(q_a));
        end
        checks++;
        if (q_d.size() != 2 || q_d[0] != 15 || q_d[1] != 36) begin
            errors++;
            $display("FAIL basic_d: got %s expected 15 36", qstr(q_d));
        end
        checks++;
        if (q_done.size() != 1 || q_done[0] != 37) begin
            errors++;
            $display("FAIL basic_done: got %s expected 37", qstr(q_done));
        end
        checks++;
        if (bus.iter_cnt !== 16'd2 || bus.div0 !== 6'd2 || bus.div1 !== 6'd4) begin
            errors++;
            $display("FAIL basic_hold: iter=%0d div0=%0d div1=%0d, expected 2 2 4", bus.iter_cnt, bus.div0, bus.div1);
        end
    endtask

    task automatic test_zero_gaps();
        set_cfg(6'd1, 6'd1, 16'd0, 16'd0, 16'd0, 16'd0, 3'b101);
        do_start();
        wait_idle("zero", 50);
        repeat (5) @(negedge clk_control);
        checks++;
        if (q_grst.size() != 1 || q_grst[0] != 5 || q_d.size() != 1 || q_d[0] != 7) begin
            errors++;
            $display("FAIL zero_grst_d: grst=%s d=%s expected grst 5 d 7", qstr(q_grst), qstr(q_d));
        end
        checks++;
        if (q_a.size() != 0) begin
            errors++;
            $display("FAIL zero_masked_a: got %s expected none", qstr(q_a));
        end
        checks++;
        if (q_done.size() != 1 || q_done[0] != 8 || bus.iter_cnt !== 16'd1) begin
            errors++;
            $display("FAIL zero_done: done=%s iter=%0d expected done 8 iter 1", qstr(q_done), bus.iter_cnt);
        end
    endtask

    task automatic test_abort();
        set_cfg(6'd7, 6'd9, 16'd3, 16'd5, 16'd10, 16'd2, 3'b111);
        do_start();
        wait_cycle(11);
        bus.abort = 1'b1;
        @(negedge clk_control);
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: busy=%b, expected 0", bus.busy);
        end
        repeat (30) @(negedge clk_control);
        checks++;
        if (q_d.size() != 0 || q_done.size() != 0 || q_grst.size() != 1 || q_a.size() != 1) begin
            errors++;
            $display("FAIL abort_pulses: grst=%s a=%s d=%s done=%s expected grst 5 a 9 d none done none",
                     qstr(q_grst), qstr(q_a), qstr(q_d), qstr(q_done));
        end
        checks++;
        if (bus.iter_cnt !== 16'd0 || bus.div0 !== 6'd7 || bus.div1 !== 6'd9) begin
            errors++;
            $display("FAIL abort_hold: iter=%0d div0=%0d div1=%0d, expected 0 7 9", bus.iter_cnt, bus.div0, bus.div1);
        end
    endtask

    task automatic test_start_busy();
        set_cfg(6'd3, 6'd5, 16'd1, 16'd1, 16'd1, 16'd1, 3'b111);
        do_start();
        wait_cycle(6);
        bus.start = 1'b1;
        @(negedge clk_control);
        bus.start = 1'b0;
        wait_idle("busy_start", 50);
        repeat (20) @(negedge clk_control);
        checks++;
        if (q_grst.size() != 1 || q_grst[0] != 5 || q_a.size() != 1 || q_a[0] != 7 ||
            q_d.size() != 1 || q_d[0] != 9 || q_done.size() != 1 || q_done[0] != 10) begin
            errors++;
            $display("FAIL busy_start_run: grst=%s a=%s d=%s done=%s expected 5 7 9 10",
                     qstr(q_grst), qstr(q_a), qstr(q_d), qstr(q_done));
        end
        clear_log();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk_control);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_busy: busy=%b, expected 0", bus.busy);
        end
        repeat (20) @(negedge clk_control);
        checks++;
        if (q_grst.size() != 0 || q_done.size() != 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle: grst=%s done=%s busy=%b expected none none 0",
                     qstr(q_grst), qstr(q_done), bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        set_cfg(6'd1, 6'd2, 16'd0, 16'd0, 16'd0, 16'd1, 3'b111);
        do_start();
        wait_idle("b2b_first", 30);
        checks++;
        if (q_done.size() != 1 || q_done[0] != 8) begin
            errors++;
            $display("FAIL b2b_first_done: got %s expected 8", qstr(q_done));
        end
        do_start();
        wait_idle("b2b_second", 30);
        checks++;
        if (q_grst.size() != 1 || q_grst[0] != 5 || q_done.size() != 1 || q_done[0] != 8) begin
            errors++;
            $display("FAIL b2b_rearm: grst=%s done=%s expected grst 5 done 8", qstr(q_grst), qstr(q_done));
        end
    endtask

    task automatic test_reset_mid_run();
        set_cfg(6'd5, 6'd6, 16'd2, 16'd2, 16'd2, 16'd3, 3'b111);
        do_start();
        wait_cycle(2);
        rst = 1'b1;
        @(negedge clk_control);
        rst = 1'b0;
        checks++;
        if ({bus.div0, bus.div1, bus.pulse_grst, bus.pulse_a, bus.pulse_d,
             bus.busy, bus.done, bus.iter_cnt} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: div0=%0d div1=%0d busy=%b done=%b iter=%0d, expected all 0",
                     bus.div0, bus.div1, bus.busy, bus.done, bus.iter_cnt);
        end
        repeat (20) @(negedge clk_control);
        checks++;
        if (q_grst.size() != 0 || q_done.size() != 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle: grst=%s done=%s busy=%b expected none none 0",
                     qstr(q_grst), qstr(q_done), bus.busy);
        end
    endtask

    task automatic test_cfg_isolation();
        set_cfg(6'd1, 6'd3, 16'd2, 16'd3, 16'd4, 16'd2, 3'b111);
        do_start();
        wait_cycle(2);
        set_cfg(6'd63, 6'd63, 16'd0, 16'd0, 16'd0, 16'd5, 3'b000);
        wait_idle("iso", 200);
        checks++;
        if (q_grst.size() != 2 || q_grst[0] != 5 || q_grst[1] != 17 ||
            q_a.size() != 2 || q_a[0] != 8 || q_a[1] != 20) begin
            errors++;
            $display("FAIL iso_grst_a: grst=%s a=%s expected grst 5 17 a 8 20", qstr(q_grst), qstr(q_a));
        end
        checks++;
        if (q_d.size() != 2 || q_d[0] != 12 || q_d[1] != 24 || q_done.size() != 1 || q_done[0] != 25) begin
            errors++;
            $display("FAIL iso_d_done: d=%s done=%s expected d 12 24 done 25", qstr(q_d), qstr(q_done));
        end
        checks++;
        if (bus.iter_cnt !== 16'd2 || bus.div0 !== 6'd1 || bus.div1 !== 6'd3) begin
            errors++;
            $display("FAIL iso_hold: iter=%0d div0=%0d div1=%0d, expected 2 1 3", bus.iter_cnt, bus.div0, bus.div1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_gaps();
        test_abort();
        test_start_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_cfg_isolation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
